// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit for the E stage.
//   Holds the architectural HI/LO registers. MULT/MULTU/DIV/DIVU latch their
//   operands on the start edge, report busy for MULT_CYCLES / DIV_CYCLES
//   cycles and commit HI/LO on the edge where busy falls. MTHI/MTLO write in
//   a single edge from IDLE without raising busy.
// Ports:
//   clk        - rising-edge clock
//   reset      - synchronous, active-high reset
//   start      - E-stage instruction is an MD op
//   MDOP[2:0]  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
//   A, B       - forwarded rs / rt operands
//   busy       - multi-cycle operation in flight (registered)
//   HI, LO     - architectural HI / LO registers
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDOP,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     op_q, op_d;      // {div, unsigned}
  logic [31:0]    a_q, a_d, b_q, b_d;
  logic [31:0]    hi_q, hi_d, lo_q, lo_d;

  // ---- datapath on the latched operands ----
  logic        sgn, a_neg, b_neg, b_zero;
  logic [63:0] a_ext, b_ext, prod;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;

  always_comb begin
    sgn    = ~op_q[0];
    // Low 64 bits of the product of sign-extended operands equal the
    // two's-complement signed product, so one multiplier serves both forms.
    a_ext  = {{32{sgn & a_q[31]}}, a_q};
    b_ext  = {{32{sgn & b_q[31]}}, b_q};
    prod   = a_ext * b_ext;
    // Signed divide on magnitudes; 0x80000000 has magnitude 0x80000000 as an
    // unsigned value, so the overflow case falls out without special handling.
    a_neg  = sgn & a_q[31];
    b_neg  = sgn & b_q[31];
    a_mag  = a_neg ? (~a_q + 32'd1) : a_q;
    b_mag  = b_neg ? (~b_q + 32'd1) : b_q;
    b_zero = (b_q == 32'd0);
    b_safe = b_zero ? 32'd1 : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    quo    = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem    = a_neg ? (~r_mag + 32'd1) : r_mag;
  end

  // ---- control ----
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (!MDOP[2]) begin
            state_d = RUN;
            op_d    = MDOP[1:0];
            a_d     = A;
            b_d     = B;
            cnt_d   = MDOP[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          end else if (MDOP == 3'b100) begin
            hi_d = A;
          end else if (MDOP == 3'b101) begin
            lo_d = A;
          end
        end
      end
      RUN: begin
        if (cnt_q == CW'(1)) begin
          // Commit edge; divide-by-zero leaves HI/LO untouched.
          if (!op_q[1]) begin
            hi_d = prod[63:32];
            lo_d = prod[31:0];
          end else if (!b_zero) begin
            hi_d = rem;
            lo_d = quo;
          end
          state_d = IDLE;
          cnt_d   = '0;
          // A new multi-cycle op may be accepted on the same edge, giving
          // back-to-back operation; MTHI/MTLO still wait for IDLE.
          if (start && !MDOP[2]) begin
            state_d = RUN;
            op_d    = MDOP[1:0];
            a_d     = A;
            b_d     = B;
            cnt_d   = MDOP[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;
endmodule
